// File: rtl/chan_arb_mux_pkg.sv
// Shared constants for the channel arbiter/mux.
// Mode encoding used by chan_arb_mux.
package chan_arb_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/chan_arb_mux_rr_arbiter.sv
// Round-robin search: first request above ptr, wrapping.
// Returns a one-hot grant, its index and a found flag.
module rr_arbiter #(
    parameter int NCH  = 8,
    parameter int SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [NCH-1:0]  grant,
    output logic [SELW-1:0] gidx,
    output logic            gvalid
);

    int idx;

    always_comb begin
        grant  = '0;
        gidx   = '0;
        gvalid = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NCH; k++) begin
            idx = (int'(ptr) + k) % NCH;
            if (!gvalid && req[idx]) begin
                gvalid     = 1'b1;
                grant[idx] = 1'b1;
                gidx       = SELW'(idx);
            end
        end
    end

endmodule

// File: rtl/chan_arb_mux.sv
// NCH-to-1 channel mux with fixed-select or round-robin grant
// and a single registered output stage.
module chan_arb_mux
    import chan_arb_mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 8,
    parameter int SELW  = $clog2(NCH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]     in_valid,
    output logic [NCH-1:0]     in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_chan,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [SELW-1:0] rr_ptr;
    logic [NCH-1:0]  rr_grant;
    logic [SELW-1:0] rr_idx;
    logic            rr_found;
    logic [NCH-1:0]  grant;
    logic [SELW-1:0] gidx;
    logic            load_en;
    logic            xfer;

    rr_arbiter #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_rr (
        .req    (in_valid),
        .ptr    (rr_ptr),
        .grant  (rr_grant),
        .gidx   (rr_idx),
        .gvalid (rr_found)
    );

    always_comb begin
        grant = '0;
        gidx  = '0;
        if (mode == MODE_RR) begin
            grant = rr_grant;
            gidx  = rr_idx;
        end else if (int'(sel) < NCH) begin
            if (in_valid[sel]) begin
                grant[sel] = 1'b1;
                gidx       = sel;
            end
        end
    end

    assign load_en  = !out_valid || out_ready;
    // Gated by rst_n so nothing is handshaken while reset is held.
    assign in_ready = (load_en && rst_n) ? grant : '0;
    assign xfer     = |in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            rr_ptr    <= SELW'(NCH - 1);
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[gidx*WIDTH +: WIDTH];
            out_chan  <= gidx;
            rr_ptr    <= gidx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    logic unused_ok;
    assign unused_ok = rr_found;

endmodule

// File: tb/tb_chan_arb_mux.sv
// Directed table-driven bench for chan_arb_mux (WIDTH=8, NCH=8).
module tb_chan_arb_mux;

    localparam int WIDTH = 8;
    localparam int NCH   = 8;
    localparam int SELW  = 3;

    logic                 clk;
    logic                 rst_n;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_chan;
    logic                 out_valid;
    logic                 out_ready;

    int n_cmp;
    int n_bad;

    chan_arb_mux #(
        .WIDTH (WIDTH),
        .NCH   (NCH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       mode;
        logic [2:0] sel;
        logic [7:0] iv;
        logic       ordy;
        logic [7:0] exp_rdy;
        logic       exp_ov;
        logic [2:0] exp_ch;
        logic [7:0] exp_data;
        logic       chk_data;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic r, logic m, logic [2:0] s,
                                logic [7:0] iv, logic ordy,
                                logic [7:0] erdy, logic eov,
                                logic [2:0] ech, logic [7:0] ed,
                                logic cd);
        vec_t v;
        v.rst_n = r;   v.mode = m;     v.sel = s;
        v.iv = iv;     v.ordy = ordy;  v.exp_rdy = erdy;
        v.exp_ov = eov; v.exp_ch = ech; v.exp_data = ed;
        v.chk_data = cd;
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    localparam logic [63:0] BASE = 64'hA7A6A5A4A3A2A1A0;

    initial begin
        logic [63:0] rd;
        logic [7:0]  exp_d;
        logic [2:0]  ch;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        mode = 1'b0;
        sel = '0;
        in_data = BASE;
        in_valid = '0;
        out_ready = 1'b1;

        // reset, fixed sel=5, missing channel 3
        tv.push_back(mk(0,0,0,8'hFF,1, 8'h00,0,0,8'h00,1));
        tv.push_back(mk(1,0,5,8'hFF,1, 8'h20,1,5,8'hA5,1));
        tv.push_back(mk(1,0,3,8'hF7,1, 8'h00,0,0,8'h00,0));
        tv.push_back(mk(1,0,3,8'hF7,1, 8'h00,0,0,8'h00,0));
        // reset then round-robin sweep over all channels
        tv.push_back(mk(0,1,0,8'hFF,1, 8'h00,0,0,8'h00,1));
        for (int k = 0; k < 10; k++) begin
            ch = 3'(k % 8);
            tv.push_back(mk(1,1,0,8'hFF,1, 8'(1 << ch),1,ch,
                            8'hA0 + 8'(ch),1));
        end
        // sparse requests with wrap-around
        tv.push_back(mk(1,1,0,8'h82,1, 8'h80,1,7,8'hA7,1));
        tv.push_back(mk(1,1,0,8'h82,1, 8'h02,1,1,8'hA1,1));
        tv.push_back(mk(1,1,0,8'h82,1, 8'h80,1,7,8'hA7,1));
        // back-pressure with sel toggling
        tv.push_back(mk(1,0,2,8'hFF,0, 8'h00,1,7,8'hA7,1));
        tv.push_back(mk(1,0,4,8'hFF,0, 8'h00,1,7,8'hA7,1));
        tv.push_back(mk(1,0,2,8'hFF,0, 8'h00,1,7,8'hA7,1));
        tv.push_back(mk(1,0,4,8'hFF,0, 8'h00,1,7,8'hA7,1));
        tv.push_back(mk(1,0,2,8'hFF,1, 8'h04,1,2,8'hA2,1));
        // fixed select on an idle channel drains the held word
        tv.push_back(mk(1,0,3,8'hF7,0, 8'h00,1,2,8'hA2,1));
        tv.push_back(mk(1,0,3,8'hF7,1, 8'h00,0,0,8'h00,0));
        // reset while holding a word
        tv.push_back(mk(1,0,6,8'hFF,1, 8'h40,1,6,8'hA6,1));
        tv.push_back(mk(0,1,0,8'hFF,0, 8'h00,0,0,8'h00,1));
        tv.push_back(mk(1,1,0,8'hFF,1, 8'h01,1,0,8'hA0,1));

        foreach (tv[i]) begin
            rst_n = tv[i].rst_n;
            mode = tv[i].mode;
            sel = tv[i].sel;
            in_valid = tv[i].iv;
            out_ready = tv[i].ordy;
            @(negedge clk);
            check($sformatf("in_ready[%0d]", i), 64'(in_ready),
                  64'(tv[i].exp_rdy));
            @(posedge clk);
            #1;
            check($sformatf("out_valid[%0d]", i), 64'(out_valid),
                  64'(tv[i].exp_ov));
            if (tv[i].chk_data) begin
                check($sformatf("out_chan[%0d]", i), 64'(out_chan),
                      64'(tv[i].exp_ch));
                check($sformatf("out_data[%0d]", i), 64'(out_data),
                      64'(tv[i].exp_data));
            end
        end

        // streaming with fresh data every cycle, pointer now at ch0
        for (int k = 1; k <= 4; k++) begin
            rd = {$urandom, $urandom};
            in_data = rd;
            mode = 1'b1;
            in_valid = 8'hFF;
            out_ready = 1'b1;
            exp_d = rd[k*8 +: 8];
            @(negedge clk);
            check($sformatf("stream_rdy[%0d]", k), 64'(in_ready),
                  64'(8'(1 << k)));
            // data changing after grant must not matter before the edge
            @(posedge clk);
            #1;
            in_data = ~rd;
            check($sformatf("stream_ch[%0d]", k), 64'(out_chan), 64'(k));
            check($sformatf("stream_data[%0d]", k), 64'(out_data),
                  64'(exp_d));
            check($sformatf("stream_ov[%0d]", k), 64'(out_valid), 64'(1));
        end

        // no requests: word drains and nothing is granted
        in_valid = '0;
        @(negedge clk);
        check("idle_rdy", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        check("idle_ov", 64'(out_valid), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
